// File: rtl/tdm_demux14_if.sv
// Bus bundle for the 1:4 TDM demultiplexer: the sample stream in, the parallel frame out.
// frame_count exists only when TDM_DEMUX_FRAME_CNT_EN is defined.
interface tdm_demux14_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_sync;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] out3;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out0;
    logic             frame_valid;
    logic             locked;
    logic             sync_err;
`ifdef TDM_DEMUX_FRAME_CNT_EN
    logic [15:0]      frame_count;
`endif

    modport master (
`ifdef TDM_DEMUX_FRAME_CNT_EN
        input  frame_count,
`endif
        output in_valid, in_sync, in_data,
        input  out3, out2, out1, out0, frame_valid, locked, sync_err
    );

    modport slave (
`ifdef TDM_DEMUX_FRAME_CNT_EN
        output frame_count,
`endif
        input  in_valid, in_sync, in_data,
        output out3, out2, out1, out0, frame_valid, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux14.sv
// Receive-side 1:4 TDM demultiplexer: hunts for frame sync, stages slots 0-2 and publishes a
// coherent 4-channel frame on slot 3. Optional frame counter under TDM_DEMUX_FRAME_CNT_EN.
module tdm_demux14 #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    tdm_demux14_if.slave bus
);
    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] stg0_q, stg0_d, stg1_q, stg1_d, stg2_q, stg2_d;
    logic [WIDTH-1:0] out3_q, out3_d, out2_q, out2_d, out1_q, out1_d, out0_q, out0_d;
    logic             fv_q, fv_d, se_q, se_d;
`ifdef TDM_DEMUX_FRAME_CNT_EN
    logic [15:0]      cnt_q, cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        stg0_d  = stg0_q;
        stg1_d  = stg1_q;
        stg2_d  = stg2_q;
        out3_d  = out3_q;
        out2_d  = out2_q;
        out1_d  = out1_q;
        out0_d  = out0_q;
        fv_d    = 1'b0;
        se_d    = 1'b0;
`ifdef TDM_DEMUX_FRAME_CNT_EN
        cnt_d   = cnt_q;
`endif
        if (bus.in_valid) begin
            if (state_q == HUNT) begin
                if (bus.in_sync) begin
                    stg0_d  = bus.in_data;
                    slot_d  = 2'd1;
                    state_d = LOCKED;
                end
            end else if (bus.in_sync) begin
                // Any sync restarts the frame; only an early one is an error.
                se_d   = (slot_q != 2'd0);
                stg0_d = bus.in_data;
                slot_d = 2'd1;
            end else begin
                case (slot_q)
                    2'd0: begin
                        se_d    = 1'b1;
                        state_d = HUNT;
                    end
                    2'd1: begin
                        stg1_d = bus.in_data;
                        slot_d = 2'd2;
                    end
                    2'd2: begin
                        stg2_d = bus.in_data;
                        slot_d = 2'd3;
                    end
                    default: begin
                        out3_d = stg0_q;
                        out2_d = stg1_q;
                        out1_d = stg2_q;
                        out0_d = bus.in_data;
                        fv_d   = 1'b1;
                        slot_d = 2'd0;
`ifdef TDM_DEMUX_FRAME_CNT_EN
                        cnt_d  = cnt_q + 16'd1;
`endif
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
            slot_q  <= 2'd0;
            stg0_q  <= '0;
            stg1_q  <= '0;
            stg2_q  <= '0;
            out3_q  <= '0;
            out2_q  <= '0;
            out1_q  <= '0;
            out0_q  <= '0;
            fv_q    <= 1'b0;
            se_q    <= 1'b0;
`ifdef TDM_DEMUX_FRAME_CNT_EN
            cnt_q   <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            stg0_q  <= stg0_d;
            stg1_q  <= stg1_d;
            stg2_q  <= stg2_d;
            out3_q  <= out3_d;
            out2_q  <= out2_d;
            out1_q  <= out1_d;
            out0_q  <= out0_d;
            fv_q    <= fv_d;
            se_q    <= se_d;
`ifdef TDM_DEMUX_FRAME_CNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.out3        = out3_q;
    assign bus.out2        = out2_q;
    assign bus.out1        = out1_q;
    assign bus.out0        = out0_q;
    assign bus.frame_valid = fv_q;
    assign bus.sync_err    = se_q;
    assign bus.locked      = (state_q == LOCKED);
`ifdef TDM_DEMUX_FRAME_CNT_EN
    assign bus.frame_count = cnt_q;
`endif
endmodule
